uart_rx_block_packer: RTL
=========================

# uart_rx_block_packer

Packs the UART receiver's byte stream into 128-bit blocks for the AES-CTR core. It sits between `uart_rx` and the AES input stage. It buffers completed blocks in a small block FIFO and hands them over on a valid/ready handshake. In builds with the timeout feature, a partial block is flushed zero-padded after an inter-byte idle timeout.

## Interface
Parameters:
- `BLK_FIFO_DEPTH`, default 4: FIFO depth in blocks; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, default 100000: idle clocks after the last byte before a partial block is flushed; ≥ 2.

Ports:
- `clk` input 1: single clock for the whole block.
- `reset` input 1: asynchronous, active-high reset.
- `rx_data` input 8: byte from `uart_rx`.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `blk_data` output 128: head block; first received byte in [127:120].
- `blk_len` output 5: number of valid bytes in the head block, 1..16.
- `blk_valid` output 1: FIFO is non-empty.
- `blk_ready` input 1: consumer accepts the head block.
- `fill_level` output $clog2(BLK_FIFO_DEPTH)+1: blocks currently stored.
- `overflow` output 1: one-cycle pulse when a block is dropped.
- `drop_count` output 8: saturating count of dropped blocks.

## Operation
- Assembly register `asm_q[127:0]` and byte counter `byte_cnt[3:0]`.
- Each `rx_valid` shifts the byte in: `asm_q <= {asm_q[119:0], rx_data}`, then `byte_cnt++`.
- 16th byte (`byte_cnt==15` and `rx_valid`) completes a block:
  - Push candidate is `{asm_q[119:0], rx_data}` with len 16, formed combinationally.
  - Pushed on the same edge; `byte_cnt` returns to 0.
- Partial flush (timeout only): push `asm_q << 8*(16-byte_cnt)` with len=`byte_cnt`. Data is left-aligned and the low bytes are zero.
- Handshake:
  - Pop occurs when `blk_valid && blk_ready`.
  - `blk_data` and `blk_len` stay stable while `blk_valid && !blk_ready`.
- Full FIFO on push:
  - If no pop is in the same cycle, the block is dropped.
  - `overflow` pulses and `drop_count` increments, saturating at 255.
  - Assembly restarts clean either way.
- Push and pop in the same cycle, including when full: both are performed, `fill_level` is unchanged, and nothing is dropped.
- Pointers are `$clog2(BLK_FIFO_DEPTH)` bits wide and wrap naturally.
- State machine `st`, two states:
  - `IDLE` → `FILL` on `rx_valid` when `byte_cnt==0`.
  - `FILL` → `IDLE` on block complete or timeout flush.
  - `FILL` holds otherwise.
- Reset mid-block discards the partial bytes. FIFO contents are lost.

## Timing
- Reset values:
  - `blk_data` = 0, `blk_len` = 0, `blk_valid` = 0.
  - `fill_level` = 0, `overflow` = 0, `drop_count` = 0.
  - Internal: `st`=`IDLE`, pointers = 0, `byte_cnt` = 0, timer = 0.
- Latency: 16th byte sampled at edge N gives `blk_valid`=1 after edge N, one cycle.
- `blk_data`/`blk_len` are a combinational read of the FIFO head entry.
- Timeout timer:
  - Cleared on every accepted byte; counts only in `FILL`.
  - Flush occurs on the edge where the timer reaches `TIMEOUT_CYCLES-1`; `blk_valid` is visible the next cycle.
- `rx_valid` in the same cycle as timer expiry: the byte wins. The byte is appended, the timer clears, and there is no flush.
- `overflow` is high for exactly one cycle per dropped block.
- Throughput: one push and one pop per cycle maximum.

## Configuration
- `UART_RX_PAD_TIMEOUT_EN` defined:
  - Timer and partial-flush path are present.
  - `blk_len` may be 1..15.
- Not defined:
  - Timer is removed.
  - Partial bytes are held indefinitely until the 16th byte arrives.
  - `blk_len` is always 16 when `blk_valid`.
  - `st` still tracks `IDLE`/`FILL`.

## Structure
- Package `uart_aes_pkg` holds:
  - Constants `AES_BLK_BYTES=16` and `AES_BLK_W=128`.
  - Typedef `aes_blk_t` as a packed struct `{logic [127:0] data; logic [4:0] len;}`.
  - Enum `pack_st_t {IDLE, FILL}`.
- One sub-module: `blk_fifo`, a synchronous FIFO of `aes_blk_t`.
  - Parameter `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`.
  - Active-high async reset.
- Top level holds assembly, timer, FSM and drop logic.

## Test plan
- Complete block:
  - Stimulus: bytes 0x00..0x0F, `blk_ready`=1.
  - Required: one block `blk_data`=128'h000102…0F, `blk_len`=16, `blk_valid` one cycle after byte 0x0F.
- Backpressure:
  - Stimulus: `blk_ready`=0, push 5 full blocks with `BLK_FIFO_DEPTH`=4.
  - Required: `fill_level`=4; the 5th block gives an `overflow` pulse and `drop_count`=1.
  - Then raise `blk_ready`: the first 4 blocks come out in order.
- Push and pop at full:
  - Stimulus: FIFO full; complete a block in the same cycle `blk_ready`=1.
  - Required: no drop, `fill_level` stays 4.
- Timeout flush (`UART_RX_PAD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20):
  - Stimulus: bytes 0xAA, 0xBB, then idle.
  - Required: block 128'hAABB0000…00, `blk_len`=2, emitted 20 cycles after 0xBB.
- Timeout race:
  - Stimulus: a byte on the exact expiry cycle.
  - Required: no flush; the byte is appended.
  - Without the macro, a 2-byte partial never emits.
- Mid-block reset:
  - Stimulus: assert `reset` after 7 bytes, then send 16 new bytes.
  - Required: outputs 0 during reset; the next block contains only the 16 new bytes.

Source files
------------

// File: rtl/uart_aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_aes_pkg
//  Description : Shared constants and types for the UART -> AES block path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BLK_W     = 128;

    typedef struct packed {
        logic [AES_BLK_W-1:0] data;
        logic [4:0]           len;
    } aes_blk_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_st_t;

endpackage
`default_nettype wire

// File: rtl/blk_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : blk_fifo
//  Description : Synchronous FIFO of AES blocks with a combinational head read.
//  Revision    : 1.0 - initial release
// ============================================================================
module blk_fifo
    import uart_aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  aes_blk_t               din,
    output aes_blk_t               dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    aes_blk_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_wr_en;
    logic                 w_rd_en;

    assign full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign dout    = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_wr_en = push && (!full || pop);
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_wr_en} - {{c_PTR_W{1'b0}}, w_rd_en};
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_block_packer
//  Description : Packs UART bytes into 128-bit blocks and queues them for AES.
//                Define UART_RX_PAD_TIMEOUT_EN to flush zero-padded partial
//                blocks after an inter-byte idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_block_packer
    import uart_aes_pkg::*;
#(
    parameter int BLK_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [AES_BLK_W-1:0]            blk_data,
    output logic [4:0]                      blk_len,
    output logic                            blk_valid,
    input  logic                            blk_ready,
    output logic [$clog2(BLK_FIFO_DEPTH):0] fill_level,
    output logic                            overflow,
    output logic [7:0]                      drop_count
);

    // At most 15 bytes are ever held; the 16th is merged straight into the push.
    logic [AES_BLK_W-9:0] r_asm_q;
    logic [3:0]           r_byte_cnt;
    pack_st_t             r_st;
    pack_st_t             w_st_nxt;
    logic                 r_overflow;
    logic [7:0]           r_drop_count;

    logic                 w_complete;
    logic                 w_flush;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [7:0]           w_pad_shift;
    aes_blk_t             w_push_blk;
    aes_blk_t             w_head;

    assign w_complete  = rx_valid && (r_byte_cnt == 4'd15);
    assign w_push      = w_complete || w_flush;
    assign w_pop       = !w_empty && blk_ready;
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_pad_shift = {5'(AES_BLK_BYTES) - {1'b0, r_byte_cnt}, 3'b000};

    always_comb begin
        w_push_blk = '0;
        if (w_complete) begin
            w_push_blk.data = {r_asm_q, rx_data};
            w_push_blk.len  = 5'(AES_BLK_BYTES);
        end else begin
            w_push_blk.data = {8'h00, r_asm_q} << w_pad_shift;
            w_push_blk.len  = {1'b0, r_byte_cnt};
        end
    end

`ifdef UART_RX_PAD_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [c_TMR_W-1:0] r_timer;

    // An arriving byte beats an expiring timer.
    assign w_flush = (r_st == FILL) && !rx_valid
                  && (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (rx_valid || (r_st != FILL) || w_flush) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    // No timer in this build; partial bytes wait for the 16th byte.
    assign w_flush = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm_q    <= '0;
            r_byte_cnt <= '0;
        end else if (w_push) begin
            r_asm_q    <= '0;
            r_byte_cnt <= '0;
        end else if (rx_valid) begin
            r_asm_q    <= {r_asm_q[AES_BLK_W-17:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st <= IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            IDLE:    if (rx_valid && (r_byte_cnt == 4'd0)) w_st_nxt = FILL;
            FILL:    if (w_complete || w_flush)            w_st_nxt = IDLE;
            default: w_st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_overflow <= w_drop;
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    blk_fifo #(
        .DEPTH (BLK_FIFO_DEPTH)
    ) u_blk_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_blk),
        .dout  (w_head),
        .count (fill_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign blk_data   = w_head.data;
    assign blk_len    = w_head.len;
    assign blk_valid  = !w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire
